// File: rtl/fifo_serial_tx.sv
// Drain stage for the 16-bit FIFO: pops one word per frame with a single-cycle
// read strobe and serializes it UART-style (start bit, data LSB first, stop bit).
module fifo_serial_tx #(
  parameter int width        = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data,
  output logic             fifo_re,
  output logic             tx,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(width - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [width-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             re_q, re_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             baud_end;

  assign baud_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (en && !fifo_empty) state_d = S_READ;
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        // FIFO presents the popped word in this cycle.
        shift_d = fifo_data;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next-state values.
    re_d   = (state_d == S_READ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_MAX);
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
    else                        tx_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_re   = re_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign word_done = done_q;

endmodule
